// File: rtl/led_display_driver_pkg.sv
// Shared definitions for the board-level seven-segment display blocks.
//
// Contents:
//   digit_idx_t : 3-bit index of one of the eight scanned digits
//   SEG_HEX     : active-low seg[6:0] ({g,f,e,d,c,b,a}) pattern for each nibble value 0..F
//   SEG_BLANK   : active-low seg[6:0] pattern with every segment off
//   AN_RESET    : digit-enable value held while in reset (digit 0 enabled)
//   SEG_RESET   : segment value held while in reset (shows "0", decimal point off)
package led_display_driver_pkg;

  typedef logic [2:0] digit_idx_t;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_RESET  = 8'hFE;
  localparam logic [7:0] SEG_RESET = 8'hC0;

endpackage

// File: rtl/seg_decoder.sv
// Combinational nibble-to-seven-segment lookup.
//
// Ports:
//   nibble : input  [3:0] hex digit to display
//   seg    : output [6:0] active-low segments {g,f,e,d,c,b,a}
module seg_decoder
  import led_display_driver_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/led_display_driver.sv
// Eight-digit multiplexed seven-segment display driver.
//
// A prescaler produces one tick every SCAN_DIV clocks; each tick advances the
// scanned digit. The displayed value is latched into a shadow register once per
// frame (when the digit index wraps 7->0) so a frame never mixes two values.
// While halt is high, the decimal point of digit 0 blinks with a half-period of
// BLINK_FRAMES frames.
//
// Parameters:
//   SCAN_DIV     : clk cycles per digit slot (>= 1)
//   BLINK_FRAMES : frames per half-period of the halt blink (>= 1)
//
// Ports:
//   clk     : input        rising-edge clock
//   rst     : input        asynchronous active-high reset
//   ledData : input  [31:0] value to display, digit 0 = least-significant nibble
//   halt    : input        CPU halted indicator
//   an      : output [7:0]  active-low digit enables, bit i = digit i
//   seg     : output [7:0]  active-low segments {dp,g,f,e,d,c,b,a}
//
// Build option:
//   LED_DISPLAY_BLANK_EN : when defined, leading-zero digits (other than digit 0)
//                          are blanked.
module led_display_driver
  import led_display_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ledData,
  input  logic        halt,
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic          wrap;
  digit_idx_t    idx;
  logic [31:0]   shadow;
  logic [BW-1:0] blink_cnt;
  logic          blink;
  logic          halt_d;

  logic [3:0]    nibble;
  logic [6:0]    hex_pat;
  logic          blank;
  logic          dp_n;

  assign tick = (pre_cnt == PW'(SCAN_DIV - 1));
  assign wrap = tick && (idx == 3'd7);

  // Prescaler, digit scan and frame-coherent shadow capture.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      idx     <= '0;
      shadow  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        idx <= idx + 3'd1;
      end
      if (wrap) begin
        shadow <= ledData;
      end
    end
  end

  // Halt blink. A wrap only counts when halt was already high on the previous
  // cycle, so a halt that rises together with a wrap starts the count at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_d    <= 1'b0;
      blink_cnt <= '0;
      blink     <= 1'b0;
    end else begin
      halt_d <= halt;
      if (!halt) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (wrap && halt_d) begin
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // NOTE: every signal driven here gets a value on every path (defaults first),
  // so no latch can be inferred.
  always_comb begin
    nibble = shadow[{idx, 2'b00} +: 4];
    blank  = 1'b0;
`ifdef LED_DISPLAY_BLANK_EN
    // Blank a digit when it and every more-significant nibble are zero.
    blank  = (idx != 3'd0) && ((shadow >> {idx, 2'b00}) == 32'd0);
`endif
    dp_n   = !((idx == 3'd0) && halt && blink);
  end

  seg_decoder u_seg_decoder (
    .nibble (nibble),
    .seg    (hex_pat)
  );

  // Registered outputs: they follow idx/shadow one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_RESET;
      seg <= SEG_RESET;
    end else begin
      an  <= ~(8'd1 << idx);
      seg <= {dp_n, blank ? SEG_BLANK : hex_pat};
    end
  end

endmodule

// File: doc/led_display_driver.md
LED_DISPLAY_DRIVER -- requirements
Module: led_display_driver

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot (legal range 1 and up).
REQ-002 SHALL have parameter BLINK_FRAMES, default 64: full scan frames per half-period of the halt blink (legal range 1 and up).
REQ-003 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port ledData, input, 32: display value driven by the CPU ecall path; level signal with no strobe.
REQ-006 SHALL have port halt, input, 1: CPU halted indicator.
REQ-007 SHALL have port an, output, 8: digit enables, active-low; bit i selects digit i, and digit 0 is the least-significant nibble.
REQ-008 SHALL have port seg, output, 8: segments {dp,g,f,e,d,c,b,a}, active-low.

Function
REQ-009 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; tick is asserted in the cycle the count equals SCAN_DIV-1; with SCAN_DIV=1, tick is asserted every cycle.
REQ-010 Digit index idx (3 bits) SHALL increment on tick and wrap 7->0.
REQ-011 On the tick where idx wraps 7->0, the shadow register SHALL capture ledData, so the display is frame-coherent; mid-frame ledData changes SHALL NOT show before the next wrap.
REQ-012 an and seg SHALL be registered and update on the cycle after tick: an = ~(1<<idx), seg[6:0] = hex pattern of shadow[4*idx+3:4*idx].
REQ-013 Hex patterns (seg[6:0], active-low): 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
REQ-014 Blink state SHALL toggle every BLINK_FRAMES frame wraps while halt=1; halt=0 SHALL clear the blink state and its frame counter synchronously.
REQ-015 seg[7] SHALL be 0 (dp lit) only when idx=0, halt=1 and blink state=1; otherwise seg[7]=1.
REQ-016 If halt rises in the same cycle as a frame wrap, the shadow capture SHALL still occur and the blink counter SHALL start from 0.

Reset
REQ-017 While rst=1: prescaler=0, idx=0, shadow=0, blink state and counter=0, an=8'hFE, seg=8'hC0, applied immediately regardless of clk.
REQ-018 After rst deasserts, the first tick SHALL occur SCAN_DIV cycles later; ledData is first captured at the first 7->0 wrap.

Configuration
REQ-019 Macro LED_DISPLAY_BLANK_EN defined: leading-zero blanking; every digit i>0 where shadow[31:4*i] is zero SHALL output seg[6:0]=7F; digit 0 is never blanked.
REQ-020 Macro LED_DISPLAY_BLANK_EN undefined: all eight digits SHALL always show their hex pattern.

Structure
REQ-021 The seven-segment pattern constants and the digit-index typedef SHALL live in the shared package, available to other board-level display blocks.
REQ-022 The nibble-to-pattern lookup SHALL be a combinational sub-module, seg_decoder; prescaler, scan, shadow and blink logic stay in led_display_driver.

Verification
REQ-023 Scenario: rst pulse mid-scan with idx=5 -> an=FE and seg=C0 in the same cycle, before any clk edge.
REQ-024 Scenario: SCAN_DIV=4, ledData=32'h1234ABCD held, after the first wrap -> idx0 seg=A1, idx1 seg=C6, idx4 seg=99, idx7 seg=F9, with each an value held 4 cycles.
REQ-025 Scenario: ledData changes 1234ABCD->0 while idx=3 -> digits 4..7 still show 1234 until the next wrap, then C0.
REQ-026 Scenario: halt=1, BLINK_FRAMES=2, SCAN_DIV=1 -> idx0 seg[7] alternates 1,1,0,0 over successive frame pairs; halt=0 -> seg[7]=1 from the next cycle on.
REQ-027 Scenario: LED_DISPLAY_BLANK_EN, ledData=32'h000000A5 -> digits 7..2 seg=FF, digit1 seg=88, digit0 seg=92; ledData=0 -> only digit0 shows C0.
REQ-028 Scenario: SCAN_DIV=1 without the macro -> an rotates FE,FD,...,7F one step per cycle and shadow is captured every 8 cycles.
